// File: rtl/kitchen_timer_core.sv
`default_nettype none
// ============================================================================
//  Module      : kitchen_timer_core
//  Description : MM:SS countdown core for the kitchen timer. Synchronises the
//                fast-clock divider output into a one-cycle enable used for
//                button auto-repeat and display blinking, counts down on a
//                1 Hz tick, raises the alarm at 00:00 and drives four BCD
//                digits.
//  Revision    : 1.0 - initial release
// ============================================================================
module kitchen_timer_core #(
  parameter int MAX_MIN      = 99,
  parameter int REPEAT_DELAY = 3,
  parameter int ALARM_SECS   = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fhz,
  input  logic       sec_tick,
  input  logic       btn_min,
  input  logic       btn_sec,
  input  logic       btn_start,
  input  logic       btn_clear,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       alarm,
  output logic       blink
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_run   = 2'd1;
  localparam logic [1:0] c_st_pause = 2'd2;
  localparam logic [1:0] c_st_alarm = 2'd3;

  // Hold counter must be able to hold REPEAT_DELAY itself (saturation value).
  localparam int c_hold_w  = (REPEAT_DELAY < 1) ? 1 : $clog2(REPEAT_DELAY + 1);
  localparam int c_alarm_w = (ALARM_SECS < 2) ? 1 : $clog2(ALARM_SECS + 1);

  localparam logic [c_hold_w-1:0]  c_hold_max   = c_hold_w'(REPEAT_DELAY);
  localparam logic [c_hold_w-1:0]  c_hold_one   = c_hold_w'(1);
  localparam logic [c_alarm_w-1:0] c_alarm_last = c_alarm_w'(ALARM_SECS - 1);
  localparam logic [c_alarm_w-1:0] c_alarm_one  = c_alarm_w'(1);

  localparam logic [3:0] c_max_min_tens = 4'(MAX_MIN / 10);
  localparam logic [3:0] c_max_min_ones = 4'(MAX_MIN % 10);

  // --------------------------------------------------------------------------
  // Registers and their next-state values
  // --------------------------------------------------------------------------
  logic       fhz_s1_q, fhz_s1_d;
  logic       fhz_s2_q, fhz_s2_d;
  logic       fhz_s3_q, fhz_s3_d;

  logic       btn_min_prev_q,   btn_min_prev_d;
  logic       btn_sec_prev_q,   btn_sec_prev_d;
  logic       btn_start_prev_q, btn_start_prev_d;
  logic       btn_clear_prev_q, btn_clear_prev_d;

  logic [1:0] state_q, state_d;

  logic [3:0] min_tens_q, min_tens_d;
  logic [3:0] min_ones_q, min_ones_d;
  logic [3:0] sec_tens_q, sec_tens_d;
  logic [3:0] sec_ones_q, sec_ones_d;

  logic [c_hold_w-1:0]  hold_q,      hold_d;
  logic [c_alarm_w-1:0] alarm_cnt_q, alarm_cnt_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic       fhz_rise;
  logic       min_rise, sec_rise, start_rise, clear_rise;
  logic       hold_active, repeat_fire;
  logic       min_act, sec_act;
  logic       time_zero, dec_to_zero;

  logic [3:0] inc_min_tens, inc_min_ones;
  logic [3:0] inc_sec_tens, inc_sec_ones;
  logic [3:0] dec_min_tens, dec_min_ones;
  logic [3:0] dec_sec_tens, dec_sec_ones;

  // Synchroniser chain and button history simply shift their inputs along.
  always_comb begin
    fhz_s1_d         = fhz;
    fhz_s2_d         = fhz_s1_q;
    fhz_s3_d         = fhz_s2_q;
    btn_min_prev_d   = btn_min;
    btn_sec_prev_d   = btn_sec;
    btn_start_prev_d = btn_start;
    btn_clear_prev_d = btn_clear;
  end

  // Edge detection, auto-repeat qualification and time-value flags.
  always_comb begin
    fhz_rise    = fhz_s2_q & ~fhz_s3_q;
    min_rise    = btn_min   & ~btn_min_prev_q;
    sec_rise    = btn_sec   & ~btn_sec_prev_q;
    start_rise  = btn_start & ~btn_start_prev_q;
    clear_rise  = btn_clear & ~btn_clear_prev_q;

    // Either set button held keeps the shared hold counter alive.
    hold_active = btn_min | btn_sec;
    repeat_fire = fhz_rise & hold_active & (hold_q == c_hold_max);

    // Minutes win whenever both buttons would act in the same cycle.
    min_act     = min_rise | (repeat_fire & btn_min);
    sec_act     = sec_rise | (repeat_fire & btn_sec & ~btn_min);

    time_zero   = (min_tens_q == 4'd0) && (min_ones_q == 4'd0) &&
                  (sec_tens_q == 4'd0) && (sec_ones_q == 4'd0);
    dec_to_zero = (min_tens_q == 4'd0) && (min_ones_q == 4'd0) &&
                  (sec_tens_q == 4'd0) && (sec_ones_q == 4'd1);
  end

  // BCD increment (set mode) and decrement-with-borrow (countdown) candidates.
  always_comb begin
    // Seconds +1: 59 wraps to 00 without touching the minutes.
    if (sec_ones_q == 4'd9) begin
      inc_sec_ones = 4'd0;
      inc_sec_tens = (sec_tens_q == 4'd5) ? 4'd0 : sec_tens_q + 4'd1;
    end else begin
      inc_sec_ones = sec_ones_q + 4'd1;
      inc_sec_tens = sec_tens_q;
    end

    // Minutes +1: MAX_MIN wraps to 00.
    if ((min_tens_q == c_max_min_tens) && (min_ones_q == c_max_min_ones)) begin
      inc_min_tens = 4'd0;
      inc_min_ones = 4'd0;
    end else if (min_ones_q == 4'd9) begin
      inc_min_tens = min_tens_q + 4'd1;
      inc_min_ones = 4'd0;
    end else begin
      inc_min_tens = min_tens_q;
      inc_min_ones = min_ones_q + 4'd1;
    end

    // Whole-time -1 with borrow through all four digits.
    dec_min_tens = min_tens_q;
    dec_min_ones = min_ones_q;
    dec_sec_tens = sec_tens_q;
    dec_sec_ones = sec_ones_q;
    if (sec_ones_q != 4'd0) begin
      dec_sec_ones = sec_ones_q - 4'd1;
    end else begin
      dec_sec_ones = 4'd9;
      if (sec_tens_q != 4'd0) begin
        dec_sec_tens = sec_tens_q - 4'd1;
      end else begin
        dec_sec_tens = 4'd5;
        if (min_ones_q != 4'd0) begin
          dec_min_ones = min_ones_q - 4'd1;
        end else begin
          dec_min_ones = 4'd9;
          dec_min_tens = min_tens_q - 4'd1;
        end
      end
    end
  end

  // Next-state logic; clear always has top priority.
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_idle: begin
        if (!clear_rise && start_rise && !time_zero) begin
          state_d = c_st_run;
        end
      end
      c_st_run: begin
        if (clear_rise) begin
          state_d = c_st_idle;
        end else if (sec_tick && dec_to_zero) begin
          // Reaching 00:00 always alarms, even if start is pressed too.
          state_d = c_st_alarm;
        end else if (start_rise) begin
          state_d = c_st_pause;
        end
      end
      c_st_pause: begin
        if (clear_rise) begin
          state_d = c_st_idle;
        end else if (start_rise) begin
          state_d = c_st_run;
        end
      end
      c_st_alarm: begin
        if (clear_rise || start_rise ||
            (sec_tick && (alarm_cnt_q == c_alarm_last))) begin
          state_d = c_st_idle;
        end
      end
      default: state_d = c_st_idle;
    endcase
  end

  // Time digits, hold counter and alarm counter updates per state.
  always_comb begin
    min_tens_d  = min_tens_q;
    min_ones_d  = min_ones_q;
    sec_tens_d  = sec_tens_q;
    sec_ones_d  = sec_ones_q;
    hold_d      = '0;
    alarm_cnt_d = '0;
    case (state_q)
      c_st_idle: begin
        // Hold counter runs only while a set button is held, saturating.
        if (hold_active) begin
          hold_d = hold_q;
          if (fhz_rise && (hold_q != c_hold_max)) begin
            hold_d = hold_q + c_hold_one;
          end
        end
        if (clear_rise) begin
          min_tens_d = 4'd0;
          min_ones_d = 4'd0;
          sec_tens_d = 4'd0;
          sec_ones_d = 4'd0;
        end else if (!start_rise) begin
          // A start press (accepted or not) suppresses setting this cycle.
          if (min_act) begin
            min_tens_d = inc_min_tens;
            min_ones_d = inc_min_ones;
          end else if (sec_act) begin
            sec_tens_d = inc_sec_tens;
            sec_ones_d = inc_sec_ones;
          end
        end
      end
      c_st_run: begin
        if (clear_rise) begin
          min_tens_d = 4'd0;
          min_ones_d = 4'd0;
          sec_tens_d = 4'd0;
          sec_ones_d = 4'd0;
        end else if (sec_tick && !time_zero) begin
          min_tens_d = dec_min_tens;
          min_ones_d = dec_min_ones;
          sec_tens_d = dec_sec_tens;
          sec_ones_d = dec_sec_ones;
        end
      end
      c_st_pause: begin
        if (clear_rise) begin
          min_tens_d = 4'd0;
          min_ones_d = 4'd0;
          sec_tens_d = 4'd0;
          sec_ones_d = 4'd0;
        end
      end
      c_st_alarm: begin
        min_tens_d = 4'd0;
        min_ones_d = 4'd0;
        sec_tens_d = 4'd0;
        sec_ones_d = 4'd0;
        if (!(clear_rise || start_rise)) begin
          alarm_cnt_d = alarm_cnt_q;
          if (sec_tick) begin
            alarm_cnt_d = (alarm_cnt_q == c_alarm_last) ? '0
                                                        : alarm_cnt_q + c_alarm_one;
          end
        end
      end
      default: begin
        min_tens_d = 4'd0;
        min_ones_d = 4'd0;
        sec_tens_d = 4'd0;
        sec_ones_d = 4'd0;
      end
    endcase
  end

  // State register plus all datapath flops, asynchronously reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fhz_s1_q         <= 1'b0;
      fhz_s2_q         <= 1'b0;
      fhz_s3_q         <= 1'b0;
      btn_min_prev_q   <= 1'b0;
      btn_sec_prev_q   <= 1'b0;
      btn_start_prev_q <= 1'b0;
      btn_clear_prev_q <= 1'b0;
      state_q          <= c_st_idle;
      min_tens_q       <= 4'd0;
      min_ones_q       <= 4'd0;
      sec_tens_q       <= 4'd0;
      sec_ones_q       <= 4'd0;
      hold_q           <= '0;
      alarm_cnt_q      <= '0;
    end else begin
      fhz_s1_q         <= fhz_s1_d;
      fhz_s2_q         <= fhz_s2_d;
      fhz_s3_q         <= fhz_s3_d;
      btn_min_prev_q   <= btn_min_prev_d;
      btn_sec_prev_q   <= btn_sec_prev_d;
      btn_start_prev_q <= btn_start_prev_d;
      btn_clear_prev_q <= btn_clear_prev_d;
      state_q          <= state_d;
      min_tens_q       <= min_tens_d;
      min_ones_q       <= min_ones_d;
      sec_tens_q       <= sec_tens_d;
      sec_ones_q       <= sec_ones_d;
      hold_q           <= hold_d;
      alarm_cnt_q      <= alarm_cnt_d;
    end
  end

  // Outputs decoded purely from registered state; blink flashes in PAUSE/ALARM.
  always_comb begin
    min_tens = min_tens_q;
    min_ones = min_ones_q;
    sec_tens = sec_tens_q;
    sec_ones = sec_ones_q;
    running  = (state_q == c_st_run);
    alarm    = (state_q == c_st_alarm);
    blink    = ((state_q == c_st_pause) || (state_q == c_st_alarm)) ? fhz_s2_q : 1'b1;
  end

endmodule
`default_nettype wire
